// File: rtl/uart_frame_decoder_pkg.sv
// Shared config for the controller-to-module sample link.
// Frame: byte 1 = sin_index[11:4], byte 2 = {sin_index[3:0], uart_id}.
package uart_frame_decoder_pkg;

    localparam int HI_BYTE_MSB   = 11;
    localparam int HI_BYTE_LSB   = 4;
    localparam int LO_NIBBLE_MSB = 3;
    localparam int LO_NIBBLE_LSB = 0;

    localparam logic [3:0] BROADCAST_ID_DEF = 4'hF;

    localparam int BAUD_DIV      = 160;
    localparam int BITS_PER_BYTE = 10;

    // About 1.5 byte times on the wire: 15 bit periods.
    localparam int GAP_TIMEOUT_DEF = (3 * BITS_PER_BYTE * BAUD_DIV) / 2;

    function automatic logic addr_match(
        input logic [3:0] id,
        input logic [3:0] own_id,
        input logic [3:0] bcast_id
    );
        return (id == own_id) || (id == bcast_id);
    endfunction

endpackage

// File: rtl/uart_frame_decoder.sv
// Reassembles two-byte sample frames from uart_rx into a 12-bit index
// with framing, gap-timeout, parity and address checks.
module uart_frame_decoder
    import uart_frame_decoder_pkg::*;
#(
    parameter logic [3:0] MODULE_ID    = 4'd1,
    parameter logic [3:0] BROADCAST_ID = BROADCAST_ID_DEF,
    parameter int         GAP_TIMEOUT  = GAP_TIMEOUT_DEF,
    parameter int         ERR_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_byte,
    input  logic             rx_done,
    input  logic             rx_parity_err,
    output logic [11:0]      sin_index,
    output logic [3:0]       uart_id,
    output logic             frame_valid,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_count,
    output logic             busy
);

    localparam int GAP_W = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic {
        WAIT_HIGH,
        WAIT_LOW
    } state_t;

    state_t           state, state_d;
    logic [GAP_W-1:0] gap, gap_d;
    logic [7:0]       hi_reg, hi_d;
    logic             accept;
    logic             drop_err;

    always_comb begin
        state_d  = state;
        gap_d    = gap;
        hi_d     = hi_reg;
        accept   = 1'b0;
        drop_err = 1'b0;
        case (state)
            WAIT_HIGH: begin
                if (rx_done) begin
                    if (rx_parity_err) begin
                        drop_err = 1'b1;
                    end else begin
                        hi_d    = rx_byte;
                        gap_d   = '0;
                        state_d = WAIT_LOW;
                    end
                end
            end
            WAIT_LOW: begin
                gap_d = gap + 1'b1;
                // A byte landing on the timeout cycle still completes the frame.
                if (rx_done && rx_parity_err) begin
                    drop_err = 1'b1;
                    state_d  = WAIT_HIGH;
                end else if (rx_done) begin
                    accept  = addr_match(rx_byte[LO_NIBBLE_MSB:LO_NIBBLE_LSB],
                                         MODULE_ID, BROADCAST_ID);
                    state_d = WAIT_HIGH;
                end else if (gap == GAP_LAST) begin
                    drop_err = 1'b1;
                    state_d  = WAIT_HIGH;
                end
            end
            default: state_d = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= WAIT_HIGH;
            gap         <= '0;
            hi_reg      <= '0;
            sin_index   <= '0;
            uart_id     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            gap         <= gap_d;
            hi_reg      <= hi_d;
            frame_valid <= accept;
            frame_err   <= drop_err;
            busy        <= (state_d == WAIT_LOW);
            if (accept) begin
                sin_index[HI_BYTE_MSB:HI_BYTE_LSB]     <= hi_reg;
                sin_index[LO_NIBBLE_MSB:LO_NIBBLE_LSB] <= rx_byte[7:4];
                uart_id <= rx_byte[LO_NIBBLE_MSB:LO_NIBBLE_LSB];
            end
            if (drop_err && (err_count != ERR_MAX)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed plus randomized bench for uart_frame_decoder against a
// frame-level reference model (byte distances, not cycle states).
module tb_uart_frame_decoder;

    localparam int         GT  = 2400;
    localparam logic [3:0] MID = 4'd1;
    localparam logic [3:0] BID = 4'hF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        rx_done = 1'b0;
    logic        rx_parity_err = 1'b0;
    logic [11:0] sin_index;
    logic [3:0]  uart_id;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  err_count;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: pending byte 1 and edges elapsed since it.
    bit          m_pend = 0;
    logic [7:0]  m_hi = '0;
    int          m_since = 0;
    logic [11:0] m_sin = '0;
    logic [3:0]  m_id = '0;
    int          m_err = 0;

    uart_frame_decoder dut (
        .clk           (clk),
        .reset         (reset),
        .rx_byte       (rx_byte),
        .rx_done       (rx_done),
        .rx_parity_err (rx_parity_err),
        .sin_index     (sin_index),
        .uart_id       (uart_id),
        .frame_valid   (frame_valid),
        .frame_err     (frame_err),
        .err_count     (err_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit ev, input bit ee);
        chk({tag, ".valid"}, 32'(frame_valid), 32'(ev));
        chk({tag, ".err"},   32'(frame_err),   32'(ee));
        chk({tag, ".sin"},   32'(sin_index),   32'(m_sin));
        chk({tag, ".id"},    32'(uart_id),     32'(m_id));
        chk({tag, ".cnt"},   32'(err_count),   32'(m_err));
        chk({tag, ".busy"},  32'(busy),        32'(m_pend));
    endtask

    function automatic void bump_err();
        if (m_err < 255) m_err++;
    endfunction

    // Called at a negedge; the byte is sampled on the next posedge.
    task automatic send_byte(input string tag, input logic [7:0] b,
                             input bit p);
        bit ev = 0;
        bit ee = 0;
        rx_done = 1'b1;
        rx_byte = b;
        rx_parity_err = p;
        @(negedge clk);
        rx_done = 1'b0;
        rx_parity_err = 1'b0;
        rx_byte = $urandom;
        if (!m_pend) begin
            if (p) begin
                ee = 1;
                bump_err();
            end else begin
                m_pend  = 1;
                m_hi    = b;
                m_since = 0;
            end
        end else begin
            m_pend = 0;
            if (p) begin
                ee = 1;
                bump_err();
            end else if (b[3:0] == MID || b[3:0] == BID) begin
                ev    = 1;
                m_sin = {m_hi, b[7:4]};
                m_id  = b[3:0];
            end
        end
        check_all(tag, ev, ee);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            bit ee = 0;
            @(negedge clk);
            if (m_pend) begin
                m_since++;
                if (m_since >= GT) begin
                    m_pend = 0;
                    ee = 1;
                    bump_err();
                end
            end
            chk({tag, ".idle_valid"}, 32'(frame_valid), 32'(0));
            chk({tag, ".idle_err"},   32'(frame_err),   32'(ee));
            chk({tag, ".idle_busy"},  32'(busy),        32'(m_pend));
        end
        chk({tag, ".idle_cnt"}, 32'(err_count), 32'(m_err));
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all("reset", 0, 0);
        reset = 1'b0;
        @(negedge clk);

        send_byte("t1_hi", 8'hAB, 0);
        idle("t1_gap", 199);
        send_byte("t1_lo", 8'hC1, 0);
        chk("t1_sin", 32'(sin_index), 32'h0ABC);

        idle("t2_pre", 3);
        send_byte("t2_hi", 8'h12, 0);
        send_byte("t2_lo", 8'h35, 0);
        chk("t2_keep", 32'(sin_index), 32'h0ABC);

        idle("t3_pre", 2);
        send_byte("t3_hi", 8'hFF, 0);
        send_byte("t3_lo", 8'h0F, 0);
        chk("t3_sin", 32'(sin_index), 32'h0FF0);

        send_byte("t4_hi", 8'h55, 0);
        idle("t4_timeout", GT);
        chk("t4_cnt", 32'(err_count), 32'd1);
        send_byte("t4_hi2", 8'hAA, 0);
        send_byte("t4_lo2", 8'hB1, 0);
        chk("t4_sin", 32'(sin_index), 32'h0AAB);

        send_byte("t5_edge_hi", 8'h9C, 0);
        idle("t5_edge_gap", GT - 1);
        send_byte("t5_edge_lo", 8'hD1, 0);
        chk("t5_edge_sin", 32'(sin_index), 32'h09CD);

        send_byte("t6_hi", 8'h33, 0);
        send_byte("t6_lo_par", 8'h41, 1);
        for (int i = 0; i < 260; i++) begin
            send_byte("t6_sat", 8'($urandom), 1);
        end
        chk("t6_sat_cnt", 32'(err_count), 32'hFF);

        send_byte("t7_hi", 8'h77, 0);
        idle("t7_mid", 5);
        reset = 1'b1;
        #1;
        m_pend = 0; m_hi = '0; m_since = 0;
        m_sin = '0; m_id = '0; m_err = 0;
        check_all("t7_async_rst", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        send_byte("t7_hi2", 8'h01, 0);
        send_byte("t7_lo2", 8'h21, 0);
        chk("t7_sin", 32'(sin_index), 32'h0012);
        idle("t7_one_pulse", 1);

        for (int f = 0; f < 40; f++) begin
            logic [3:0] id;
            int sel;
            int gap;
            sel = int'($urandom_range(0, 3));
            id = (sel == 0) ? MID : (sel == 1) ? BID : 4'($urandom);
            sel = int'($urandom_range(0, 9));
            gap = (sel == 0) ? GT - 1 :
                  (sel == 1) ? GT :
                  int'($urandom_range(0, 30));
            send_byte("rnd_hi", 8'($urandom), ($urandom_range(0, 9) == 0));
            idle("rnd_gap", gap);
            send_byte("rnd_lo", {4'($urandom), id},
                      ($urandom_range(0, 9) == 0));
            idle("rnd_tail", int'($urandom_range(0, 3)));
        end
        idle("final", GT + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
